fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Issue/capture stage directly upstream of the combinational FPU datapath.
- Accepts one FP operation at a time over a valid/ready handshake and registers DATA1/DATA2/DATA3/SELECT.
- Holds those registers stable for a per-opcode multicycle latency, captures the FPU result, and presents it with a destination tag to writeback over a second valid/ready handshake.
- Turns the FPU's long combinational paths into declared multicycle paths.

Parameters:
- LAT_ADDSUB, 2: cycles allowed for FADD/FSUB (SELECT 00001, 00010).
- LAT_MUL, 3: cycles for FMUL (00011).
- LAT_DIV, 8: cycles for FDIV (00100) and FSQRT (01101).
- LAT_FMA, 5: cycles for FMADD/FMSUB/FNMADD/FNMSUB (01110–10001).
- LAT_OTHER, 1: cycles for every other SELECT, including undefined codes.

Ports:
- CLK  in  1  Single clock; all state updates on the rising edge.
- RESETN  in  1  Asynchronous, active-low reset.
- IN_VALID  in  1  Upstream operation valid.
- IN_READY  out  1  Stage can accept an operation this cycle.
- IN_DATA1  in  32  Operand 1.
- IN_DATA2  in  32  Operand 2.
- IN_DATA3  in  32  Operand 3 (fused ops).
- IN_SELECT  in  5  FPU operation code.
- IN_RD  in  5  Destination register tag.
- FLUSH  in  1  Synchronous kill of the in-flight or pending operation.
- FPU_DATA1  out  32  Registered operand 1 to the FPU.
- FPU_DATA2  out  32  Registered operand 2 to the FPU.
- FPU_DATA3  out  32  Registered operand 3 to the FPU.
- FPU_SELECT  out  5  Registered operation code to the FPU.
- FPU_RESULT  in  32  Combinational FPU result.
- OUT_VALID  out  1  Result valid to writeback.
- OUT_READY  in  1  Writeback accepts the result.
- OUT_RESULT  out  32  Captured result.
- OUT_RD  out  5  Tag of the captured result.
- BUSY  out  1  High when state is not IDLE.

Behaviour:
- Reset (RESETN low, asynchronous):
  - state=IDLE; counter=0.
  - FPU_DATA1..3=0, FPU_SELECT=0, OUT_RESULT=0, OUT_RD=0.
  - OUT_VALID=0, BUSY=0. IN_READY=1 once RESETN deasserts.
  - Reset mid-operation discards the operation; no OUT_VALID is produced for it.
- States: IDLE, EXEC, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch IN_DATA1..3, IN_SELECT and IN_RD; load counter=L(IN_SELECT); go to EXEC.
- EXEC:
  - IN_READY=0.
  - FPU_* registers are held constant.
  - counter decrements each cycle.
  - In the cycle counter==1: capture FPU_RESULT into OUT_RESULT and go to DONE.
- DONE:
  - OUT_VALID=1; OUT_RESULT and OUT_RD are held stable until OUT_READY.
  - IN_READY=OUT_READY.
  - OUT_READY without IN_VALID: go to IDLE.
  - OUT_READY with IN_VALID: accept the new operation directly into EXEC, giving back-to-back issue with no bubble.
- Latency: operation accepted at edge 0 -> OUT_VALID first high in cycle L+1. Throughput is one operation per L+1 cycles when OUT_READY is held high.
- L(sel) is selected by opcode class as listed under Parameters.
- Any latency parameter set to 0 is treated as 1.
- Counter width is $clog2(max latency + 1).
- FLUSH:
  - Highest priority. Next state is IDLE and OUT_VALID drops on the next edge.
  - IN_READY is forced to 0 in a FLUSH cycle, so no operation is accepted that cycle.
  - FPU_* registers keep their values; the captured result is discarded.
- OUT_VALID must never drop without OUT_READY, except on FLUSH or reset.
- Undefined SELECT codes complete in LAT_OTHER cycles with whatever the FPU returns (0).

Decomposition:
- Package fpu_pkg:
  - SELECT opcode localparams (FADD=00001 … FCLASS=10100).
  - State encodings IDLE=2'b00, EXEC=2'b01, DONE=2'b10.
  - Latency-class function.
- Sub-module fpu_latency_lut: combinational SELECT -> L, parameterised with the five latency parameters; instantiated once.

Test Plan:
- FADD: DATA1=3F800000, DATA2=40000000, SELECT=00001, OUT_READY=1 -> OUT_VALID high in cycle 3 exactly, OUT_RESULT=40400000, OUT_RD echoed; IN_READY low in cycles 1–2.
- FMUL then FMADD back-to-back:
  - FMUL 40000000 × 40400000 -> 40C00000 in cycle 4.
  - FMADD issued in the handshake cycle with DATA3=3F800000 -> 40E00000 exactly 6 cycles later, with no IDLE cycle in between.
- Backpressure: hold OUT_READY=0 for 5 cycles after OUT_VALID -> OUT_RESULT/OUT_RD stable, IN_READY=0, BUSY=1; release -> one transfer only.
- FLUSH during EXEC of an FDIV (cycle 4 of 8) -> state IDLE next cycle, no OUT_VALID pulse; an IN_VALID asserted in the FLUSH cycle is not accepted (IN_READY=0).
- Reset mid-op: RESETN low asynchronously in cycle 2 of FMUL -> all outputs 0 immediately; after release, a new FSGNJN (3F800000, 3F800000) -> BF800000 in cycle 2.
- Undefined SELECT=11111 -> OUT_VALID in cycle 2 with OUT_RESULT=00000000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue/capture stage: opcodes, FSM states,
// and the opcode-to-latency-class mapping.
package fpu_pkg;

  localparam logic [4:0] FADD   = 5'b00001;
  localparam logic [4:0] FSUB   = 5'b00010;
  localparam logic [4:0] FMUL   = 5'b00011;
  localparam logic [4:0] FDIV   = 5'b00100;
  localparam logic [4:0] FSQRT  = 5'b01101;
  localparam logic [4:0] FMADD  = 5'b01110;
  localparam logic [4:0] FMSUB  = 5'b01111;
  localparam logic [4:0] FNMADD = 5'b10000;
  localparam logic [4:0] FNMSUB = 5'b10001;
  localparam logic [4:0] FCLASS = 5'b10100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    LC_ADDSUB,
    LC_MUL,
    LC_DIV,
    LC_FMA,
    LC_OTHER
  } lat_class_t;

  // Every opcode not named here, including undefined codes, is LC_OTHER.
  function automatic lat_class_t lat_class(input logic [4:0] sel);
    case (sel)
      FADD, FSUB:                     lat_class = LC_ADDSUB;
      FMUL:                           lat_class = LC_MUL;
      FDIV, FSQRT:                    lat_class = LC_DIV;
      FMADD, FMSUB, FNMADD, FNMSUB:   lat_class = LC_FMA;
      FCLASS:                         lat_class = LC_OTHER;
      default:                        lat_class = LC_OTHER;
    endcase
  endfunction

  // A zero latency would never let the counter reach 1, so it behaves as 1.
  function automatic int unsigned lat_clamp(input int unsigned l);
    return (l == 0) ? 1 : l;
  endfunction

  function automatic int unsigned lat_max(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = lat_clamp(a);
    if (lat_clamp(b) > m) m = lat_clamp(b);
    if (lat_clamp(c) > m) m = lat_clamp(c);
    if (lat_clamp(d) > m) m = lat_clamp(d);
    if (lat_clamp(e) > m) m = lat_clamp(e);
    return m;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Issue and writeback valid/ready handshakes of the FPU issue stage.
interface fpu_issue_ctrl_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA1;
  logic [31:0] IN_DATA2;
  logic [31:0] IN_DATA3;
  logic [4:0]  IN_SELECT;
  logic [4:0]  IN_RD;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_RESULT;
  logic [4:0]  OUT_RD;

  // Pipeline side: upstream issuer and writeback consumer.
  modport master (
    output IN_VALID, IN_DATA1, IN_DATA2, IN_DATA3, IN_SELECT, IN_RD, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_RESULT, OUT_RD
  );

  // Issue stage side.
  modport slave (
    input  IN_VALID, IN_DATA1, IN_DATA2, IN_DATA3, IN_SELECT, IN_RD, OUT_READY,
    output IN_READY, OUT_VALID, OUT_RESULT, OUT_RD
  );
endinterface

// File: rtl/fpu_latency_lut.sv
// Combinational opcode -> multicycle latency lookup.
module fpu_latency_lut
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB = 2,
  parameter int unsigned LAT_MUL    = 3,
  parameter int unsigned LAT_DIV    = 8,
  parameter int unsigned LAT_FMA    = 5,
  parameter int unsigned LAT_OTHER  = 1,
  parameter int unsigned CW         = 4
) (
  input  logic [4:0]    i_select,
  output logic [CW-1:0] o_lat
);

  // Map the opcode class to its clamped latency.
  always_comb begin
    case (lat_class(i_select))
      LC_ADDSUB: o_lat = CW'(lat_clamp(LAT_ADDSUB));
      LC_MUL:    o_lat = CW'(lat_clamp(LAT_MUL));
      LC_DIV:    o_lat = CW'(lat_clamp(LAT_DIV));
      LC_FMA:    o_lat = CW'(lat_clamp(LAT_FMA));
      default:   o_lat = CW'(lat_clamp(LAT_OTHER));
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/capture stage in front of the combinational FPU: registers the
// operands, holds them for the opcode's multicycle latency, captures the
// result and hands it to writeback.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned LAT_ADDSUB = 2,
  parameter int unsigned LAT_MUL    = 3,
  parameter int unsigned LAT_DIV    = 8,
  parameter int unsigned LAT_FMA    = 5,
  parameter int unsigned LAT_OTHER  = 1
) (
  input  logic               CLK,
  input  logic               RESETN,
  fpu_issue_ctrl_if.slave    bus,
  input  logic               FLUSH,
  output logic [31:0]        FPU_DATA1,
  output logic [31:0]        FPU_DATA2,
  output logic [31:0]        FPU_DATA3,
  output logic [4:0]         FPU_SELECT,
  input  logic [31:0]        FPU_RESULT,
  output logic               BUSY
);

  localparam int unsigned LMAX = lat_max(LAT_ADDSUB, LAT_MUL, LAT_DIV, LAT_FMA, LAT_OTHER);
  localparam int unsigned CW   = $clog2(LMAX + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_d1, r_d2, r_d3, r_res;
  logic [4:0]    r_sel, r_rd;
  logic          r_valid, r_busy;
  logic [CW-1:0] w_lat;
  logic          w_in_ready;
  logic          w_accept;

  fpu_latency_lut #(
    .LAT_ADDSUB (LAT_ADDSUB),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV),
    .LAT_FMA    (LAT_FMA),
    .LAT_OTHER  (LAT_OTHER),
    .CW         (CW)
  ) u_lut (
    .i_select (bus.IN_SELECT),
    .o_lat    (w_lat)
  );

  // Ready in IDLE, or in DONE when writeback is draining the result; never on FLUSH.
  always_comb begin
    w_in_ready = 1'b0;
    if (!FLUSH) begin
      w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.OUT_READY);
    end
    w_accept = bus.IN_VALID && w_in_ready;
  end

  // Issue FSM. Acceptance from IDLE and the back-to-back path out of DONE
  // share a single branch, so a DONE cycle with a new op goes straight to EXEC.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_d3    <= '0;
      r_sel   <= '0;
      r_res   <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (FLUSH) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_d1    <= bus.IN_DATA1;
      r_d2    <= bus.IN_DATA2;
      r_d3    <= bus.IN_DATA3;
      r_sel   <= bus.IN_SELECT;
      r_rd    <= bus.IN_RD;
      r_cnt   <= w_lat;
      r_state <= EXEC;
      r_valid <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        EXEC: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_res   <= FPU_RESULT;
            r_state <= DONE;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.OUT_READY) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY   = w_in_ready;
  assign bus.OUT_VALID  = r_valid;
  assign bus.OUT_RESULT = r_res;
  assign bus.OUT_RD     = r_rd;
  assign FPU_DATA1      = r_d1;
  assign FPU_DATA2      = r_d2;
  assign FPU_DATA3      = r_d3;
  assign FPU_SELECT     = r_sel;
  assign BUSY           = r_busy;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl with a small behavioural FPU model.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam logic [4:0] SEL_FSGNJN = 5'b00111;
  localparam logic [4:0] SEL_UNDEF  = 5'b11111;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] FPU_DATA1, FPU_DATA2, FPU_DATA3, FPU_RESULT;
  logic [4:0]  FPU_SELECT;
  logic        BUSY;

  fpu_issue_ctrl_if bus();

  fpu_issue_ctrl #(
    .LAT_ADDSUB (2),
    .LAT_MUL    (3),
    .LAT_DIV    (8),
    .LAT_FMA    (5),
    .LAT_OTHER  (1)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .bus        (bus),
    .FLUSH      (FLUSH),
    .FPU_DATA1  (FPU_DATA1),
    .FPU_DATA2  (FPU_DATA2),
    .FPU_DATA3  (FPU_DATA3),
    .FPU_SELECT (FPU_SELECT),
    .FPU_RESULT (FPU_RESULT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // FPU model: exact answers for the vectors used, distinct junk otherwise.
  always_comb begin
    FPU_RESULT = 32'h0;
    case (FPU_SELECT)
      FADD:  FPU_RESULT = (FPU_DATA1 == 32'h3F800000 && FPU_DATA2 == 32'h40000000)
                          ? 32'h40400000 : (32'hA0DD0000 ^ FPU_DATA1 ^ FPU_DATA2);
      FMUL:  FPU_RESULT = (FPU_DATA1 == 32'h40000000 && FPU_DATA2 == 32'h40400000)
                          ? 32'h40C00000 : (32'h3E110000 ^ FPU_DATA1 ^ FPU_DATA2);
      FMADD: FPU_RESULT = (FPU_DATA1 == 32'h40000000 && FPU_DATA2 == 32'h40400000 &&
                           FPU_DATA3 == 32'h3F800000)
                          ? 32'h40E00000 : (32'hFAAD0000 ^ FPU_DATA1 ^ FPU_DATA3);
      FDIV:  FPU_RESULT = FPU_DATA1 ^ FPU_DATA2;
      SEL_FSGNJN: FPU_RESULT = {~FPU_DATA2[31], FPU_DATA1[30:0]};
      default: FPU_RESULT = 32'h0;
    endcase
  end

  function automatic int unsigned tb_lat(input logic [4:0] sel);
    case (sel)
      5'b00001, 5'b00010:                     return 2;
      5'b00011:                               return 3;
      5'b00100, 5'b01101:                     return 8;
      5'b01110, 5'b01111, 5'b10000, 5'b10001: return 5;
      default:                                return 1;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   seen    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [4:0] rd, input logic [31:0] exp_res,
                       input bit expect_out, output int unsigned acc_edge);
    int n = 0;
    bus.IN_VALID  = 1'b1;
    bus.IN_SELECT = sel;
    bus.IN_DATA1  = a;
    bus.IN_DATA2  = b;
    bus.IN_DATA3  = c;
    bus.IN_RD     = rd;
    #1;
    while (!bus.IN_READY && n < 50) begin
      @(negedge CLK); #1;
      n++;
    end
    check("issue_ready", bus.IN_READY, 1);
    acc_edge = cyc + 1;
    if (expect_out) sb.push_back('{res: exp_res, rd: rd, cyc: acc_edge + tb_lat(sel)});
    @(negedge CLK);
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA1  = $urandom;
    bus.IN_DATA2  = $urandom;
    bus.IN_DATA3  = $urandom;
    bus.IN_SELECT = 5'($urandom);
    bus.IN_RD     = 5'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("drain", sb.size(), 0);
    sb.delete();
  endtask

  // Output monitor: first-valid cycle, result/tag on every valid cycle, pop on transfer.
  initial begin
    forever begin
      @(negedge CLK); #2;
      if (!RESETN) begin
        seen = 1'b0;
      end else if (bus.OUT_VALID) begin
        if (sb.size() == 0) begin
          check("spurious_valid", bus.OUT_VALID, 0);
        end else begin
          if (!seen) check("latency", cyc, sb[0].cyc);
          check("result", bus.OUT_RESULT, sb[0].res);
          check("rd", bus.OUT_RD, sb[0].rd);
          seen = 1'b1;
          if (bus.OUT_READY) begin
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned e1, e2;
    int n;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA1  = '0;
    bus.IN_DATA2  = '0;
    bus.IN_DATA3  = '0;
    bus.IN_SELECT = '0;
    bus.IN_RD     = '0;
    bus.OUT_READY = 1'b1;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    check("rst_busy", BUSY, 0);
    check("rst_out_valid", bus.OUT_VALID, 0);
    check("rst_out_result", bus.OUT_RESULT, 0);
    check("rst_out_rd", bus.OUT_RD, 0);
    check("rst_fpu_data1", FPU_DATA1, 0);
    check("rst_fpu_select", FPU_SELECT, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    #1;
    check("rst_in_ready", bus.IN_READY, 1);
    @(negedge CLK);

    // FADD with IN_READY low through EXEC
    issue(FADD, 32'h3F800000, 32'h40000000, 32'h0, 5'd5, 32'h40400000, 1, e1);
    #1;
    check("fadd_in_ready_c1", bus.IN_READY, 0);
    @(negedge CLK); #1;
    check("fadd_in_ready_c2", bus.IN_READY, 0);
    @(negedge CLK);
    drain();

    // FMUL then FMADD back-to-back
    issue(FMUL, 32'h40000000, 32'h40400000, 32'h0, 5'd1, 32'h40C00000, 1, e1);
    issue(FMADD, 32'h40000000, 32'h40400000, 32'h3F800000, 5'd2, 32'h40E00000, 1, e2);
    check("b2b_accept_edge", e2, e1 + 4);
    drain();

    // Backpressure
    bus.OUT_READY = 1'b0;
    issue(FADD, 32'h3F800000, 32'h40000000, 32'h0, 5'd9, 32'h40400000, 1, e1);
    #1;
    n = 0;
    while (!bus.OUT_VALID && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    check("bp_valid", bus.OUT_VALID, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", bus.IN_READY, 0);
      check("bp_busy", BUSY, 1);
      check("bp_hold_valid", bus.OUT_VALID, 1);
      @(negedge CLK); #1;
    end
    bus.OUT_READY = 1'b1;
    @(negedge CLK); #1;
    check("bp_single_xfer", bus.OUT_VALID, 0);
    check("bp_idle", BUSY, 0);
    check("bp_sb_empty", sb.size(), 0);
    @(negedge CLK);

    // FLUSH in cycle 4 of an FDIV, with a competing IN_VALID
    issue(FDIV, 32'h40000000, 32'h3F800000, 32'h0, 5'd3, 32'h0, 0, e1);
    repeat (3) @(negedge CLK);
    FLUSH         = 1'b1;
    bus.IN_VALID  = 1'b1;
    bus.IN_SELECT = SEL_FSGNJN;
    bus.IN_DATA1  = 32'h11111111;
    bus.IN_RD     = 5'd12;
    #1;
    check("flush_in_ready", bus.IN_READY, 0);
    @(negedge CLK);
    FLUSH        = 1'b0;
    bus.IN_VALID = 1'b0;
    #1;
    check("flush_idle", BUSY, 0);
    check("flush_no_valid", bus.OUT_VALID, 0);
    check("flush_keep_data1", FPU_DATA1, 32'h40000000);
    check("flush_keep_select", FPU_SELECT, FDIV);
    repeat (12) @(negedge CLK);

    // Asynchronous reset in cycle 2 of an FMUL
    issue(FMUL, 32'h40000000, 32'h40400000, 32'h0, 5'd4, 32'h0, 0, e1);
    @(negedge CLK);
    #3 RESETN = 1'b0;
    #1;
    check("arst_busy", BUSY, 0);
    check("arst_out_valid", bus.OUT_VALID, 0);
    check("arst_fpu_data1", FPU_DATA1, 0);
    check("arst_fpu_data2", FPU_DATA2, 0);
    check("arst_fpu_select", FPU_SELECT, 0);
    check("arst_out_result", bus.OUT_RESULT, 0);
    check("arst_out_rd", bus.OUT_RD, 0);
    @(negedge CLK);
    RESETN = 1'b1;
    #1;
    check("arst_in_ready", bus.IN_READY, 1);
    repeat (6) @(negedge CLK);

    // FSGNJN after reset, then an undefined opcode
    issue(SEL_FSGNJN, 32'h3F800000, 32'h3F800000, 32'h0, 5'd6, 32'hBF800000, 1, e1);
    drain();
    issue(SEL_UNDEF, 32'h12345678, 32'h9ABCDEF0, 32'h0, 5'd8, 32'h00000000, 1, e1);
    drain();

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
